// File: rtl/dcache_data_ctrl.sv
// rtl/dcache_data_ctrl.sv - D-cache data array sequencer and CPU/miss arbiter
module dcache_data_ctrl #(
  parameter int INDEX_W = 7,
  parameter int LINE_W  = 256,
  parameter int BEATS   = 8,
  localparam int WORD_W = $clog2(BEATS)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [INDEX_W-1:0] cpu_index,
  input  logic [WORD_W-1:0]  cpu_word,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_wstrb,
  output logic               cpu_ack,
  output logic               cpu_rvalid,
  output logic [LINE_W-1:0]  cpu_rdata,
  input  logic               miss_req,
  input  logic [INDEX_W-1:0] miss_index,
  input  logic               miss_dirty,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [LINE_W-1:0]  wb_data,
  input  logic               rf_valid,
  input  logic [31:0]        rf_data,
  output logic               miss_done,
  output logic               bram_wea,
  output logic               bram_web,
  output logic [INDEX_W-1:0] bram_addra,
  output logic [INDEX_W-1:0] bram_addrb,
  output logic [LINE_W-1:0]  bram_dina,
  output logic [LINE_W-1:0]  bram_dinb,
  input  logic [LINE_W-1:0]  bram_douta,
  input  logic [LINE_W-1:0]  bram_doutb
);

  typedef enum logic [2:0] {
    IDLE, LD_DATA, ST_MERGE, WB_RD, WB_SEND, REFILL, RF_WR
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    cnt_q;
  logic [INDEX_W-1:0]   cpu_idx_q;
  logic [WORD_W-1:0]    word_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic [INDEX_W-1:0]   miss_idx_q;
  logic [LINE_W-1:0]    wb_q;
  logic [BEATS-1:0][31:0] lbuf_q;
  logic [LINE_W-1:0]    merged;
  logic                 cpu_take;
  logic                 miss_take;

  // Miss traffic wins arbitration; CPU is only taken from IDLE
  assign miss_take = (state_q == IDLE) && miss_req;
  assign cpu_take  = (state_q == IDLE) && !miss_req && cpu_req;
  assign wb_data   = wb_q;

  // Overlay the latched store bytes onto the line read back on port A
  always_comb begin
    merged = bram_douta;
    for (int w = 0; w < BEATS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (word_q == WORD_W'(w) && wstrb_q[b]) begin
          merged[w*32 + b*8 +: 8] = wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // Next state plus every BRAM and handshake output
  always_comb begin
    state_d    = state_q;
    cpu_ack    = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    wb_valid   = 1'b0;
    miss_done  = 1'b0;
    bram_wea   = 1'b0;
    bram_web   = 1'b0;
    bram_addra = '0;
    bram_addrb = '0;
    bram_dina  = '0;
    bram_dinb  = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          bram_addrb = miss_index;
          state_d    = miss_dirty ? WB_RD : REFILL;
        end else if (cpu_req) begin
          bram_addra = cpu_index;
          cpu_ack    = 1'b1;
          state_d    = cpu_we ? ST_MERGE : LD_DATA;
        end
      end
      LD_DATA: begin
        cpu_rdata  = bram_douta;
        cpu_rvalid = 1'b1;
        state_d    = IDLE;
      end
      ST_MERGE: begin
        bram_wea   = 1'b1;
        bram_addra = cpu_idx_q;
        bram_dina  = merged;
        state_d    = IDLE;
      end
      WB_RD: begin
        bram_addrb = miss_idx_q;
        state_d    = WB_SEND;
      end
      WB_SEND: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = REFILL;
      end
      REFILL: begin
        if (rf_valid && cnt_q == WORD_W'(BEATS-1)) state_d = RF_WR;
      end
      RF_WR: begin
        bram_web   = 1'b1;
        bram_addrb = miss_idx_q;
        bram_dinb  = lbuf_q;
        miss_done  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latches, victim capture and refill line assembly
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cpu_idx_q  <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      miss_idx_q <= '0;
      wb_q       <= '0;
      lbuf_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cpu_take) begin
        cpu_idx_q <= cpu_index;
        word_q    <= cpu_word;
        wdata_q   <= cpu_wdata;
        wstrb_q   <= cpu_wstrb;
      end
      if (miss_take) begin
        miss_idx_q <= miss_index;
        cnt_q      <= '0;
      end
      if (state_q == WB_RD) wb_q <= bram_doutb;
      if (state_q == REFILL && rf_valid) begin
        lbuf_q[cnt_q] <= rf_data;
        cnt_q         <= cnt_q + 1'b1;
      end
      if (state_q == RF_WR) cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// tb/tb_dcache_data_ctrl.sv - randomized self-checking bench for dcache_data_ctrl
module tb_dcache_data_ctrl;
  localparam int NB = 8;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [6:0]   cpu_index = '0;
  logic [2:0]   cpu_word = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_wstrb = '0;
  logic         cpu_ack, cpu_rvalid;
  logic [255:0] cpu_rdata;
  logic         miss_req = 1'b0, miss_dirty = 1'b0;
  logic [6:0]   miss_index = '0;
  logic         wb_valid, wb_ready = 1'b0;
  logic [255:0] wb_data;
  logic         rf_valid = 1'b0;
  logic [31:0]  rf_data = '0;
  logic         miss_done, bram_wea, bram_web;
  logic [6:0]   bram_addra, bram_addrb;
  logic [255:0] bram_dina, bram_dinb, bram_douta, bram_doutb;

  dcache_data_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_index(cpu_index), .cpu_word(cpu_word),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ack(cpu_ack),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .miss_req(miss_req), .miss_index(miss_index), .miss_dirty(miss_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .rf_valid(rf_valid), .rf_data(rf_data), .miss_done(miss_done),
    .bram_wea(bram_wea), .bram_web(bram_web), .bram_addra(bram_addra), .bram_addrb(bram_addrb),
    .bram_dina(bram_dina), .bram_dinb(bram_dinb), .bram_douta(bram_douta), .bram_doutb(bram_doutb)
  );

  always #5 aclk = ~aclk;

  // Dual-port BRAM: registered read, read-before-write
  logic [255:0] mem [128];
  always @(posedge aclk) begin
    bram_douta <= mem[bram_addra];
    bram_doutb <= mem[bram_addrb];
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_web) mem[bram_addrb] <= bram_dinb;
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Reference model: expected array contents and the cycles at which results are due
  logic [255:0] ref_mem [128];
  int           ld_due = -1, st_due = -1, done_due = -1;
  logic [255:0] ld_line, st_line, done_line;
  logic [6:0]   st_idx, done_idx;
  int           n_cmp = 0, n_fail = 0;
  logic [255:0] last_rdata, last_dina, last_dinb;
  logic         last_done;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [255:0] merge_line(logic [255:0] line, int word, logic [31:0] d, logic [3:0] s);
    logic [255:0] r;
    r = line;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[(word*4 + b)*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Compare process: every cycle out of reset
  always @(negedge aclk) begin
    if (aresetn) begin
      chk("port_excl", bram_wea & bram_web, 0);
      chk("ack_no_req", cpu_ack & ~cpu_req, 0);
      chk("ack_during_miss", cpu_ack & miss_req, 0);
      if (cyc == ld_due) begin
        chk("rvalid", cpu_rvalid, 1);
        chk("rdata", cpu_rdata, ld_line);
      end else chk("rvalid_idle", cpu_rvalid, 0);
      if (cyc == st_due) begin
        chk("wea", bram_wea, 1);
        chk("addra", bram_addra, st_idx);
        chk("dina", bram_dina, st_line);
      end else chk("wea_idle", bram_wea, 0);
      if (cyc == done_due) begin
        chk("web", bram_web, 1);
        chk("miss_done", miss_done, 1);
        chk("addrb", bram_addrb, done_idx);
        chk("dinb", bram_dinb, done_line);
      end else begin
        chk("web_idle", bram_web, 0);
        chk("miss_done_idle", miss_done, 0);
      end
      if (cpu_ack) begin
        if (cpu_we) begin
          st_line = merge_line(ref_mem[cpu_index], int'(cpu_word), cpu_wdata, cpu_wstrb);
          ref_mem[cpu_index] = st_line;
          st_idx = cpu_index;
          st_due = cyc + 1;
        end else begin
          ld_line = ref_mem[cpu_index];
          ld_due = cyc + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ack"}, cpu_ack, 0);
    chk({tag, "_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_wbvalid"}, wb_valid, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_done"}, miss_done, 0);
    chk({tag, "_wea"}, bram_wea, 0);
    chk({tag, "_web"}, bram_web, 0);
    chk({tag, "_addra"}, bram_addra, 0);
    chk({tag, "_addrb"}, bram_addrb, 0);
    chk({tag, "_dina"}, bram_dina, 0);
    chk({tag, "_dinb"}, bram_dinb, 0);
  endtask

  task automatic do_cpu(input logic we, input logic [6:0] idx, input logic [2:0] w,
                        input logic [31:0] d, input logic [3:0] s);
    cpu_req = 1'b1; cpu_we = we; cpu_index = idx; cpu_word = w; cpu_wdata = d; cpu_wstrb = s;
    @(negedge aclk);
    chk("ack", cpu_ack, 1);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge aclk);
    last_rdata = cpu_rdata;
    last_dina = bram_dina;
    step();
  endtask

  task automatic do_miss(input logic [6:0] idx, input logic dirty, input int hold,
                         input logic with_cpu, input logic [6:0] cidx, input logic [255:0] line);
    logic [255:0] exp_wb;
    exp_wb = ref_mem[idx];
    miss_req = 1'b1; miss_index = idx; miss_dirty = dirty;
    if (with_cpu) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_index = cidx;
    end
    rf_valid = 1'b1; rf_data = $urandom;
    if (dirty) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge aclk);
        chk("wb_early", wb_valid, 0);
        step();
        rf_data = $urandom;
      end
      for (int k = 0; k <= hold; k++) begin
        wb_ready = (k == hold);
        @(negedge aclk);
        chk("wb_valid", wb_valid, 1);
        chk("wb_data", wb_data, exp_wb);
        step();
        rf_data = $urandom;
      end
      wb_ready = 1'b0;
    end else step();
    for (int i = 0; i < NB; i++) begin
      rf_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      rf_valid = 1'b1;
      rf_data = line[i*32 +: 32];
      if (i == NB - 1) begin
        done_due = cyc + 1; done_idx = idx; done_line = line; ref_mem[idx] = line;
      end
      @(negedge aclk);
      chk("wb_after_hs", wb_valid, 0);
      step();
    end
    rf_valid = 1'b0; rf_data = '0;
    @(negedge aclk);
    last_dinb = bram_dinb;
    last_done = miss_done;
    step();
    miss_req = 1'b0; miss_dirty = 1'b0;
    if (with_cpu) begin
      @(negedge aclk);
      chk("ack_after_miss", cpu_ack, 1);
      step();
      cpu_req = 1'b0;
      @(negedge aclk);
      last_rdata = cpu_rdata;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int op;
    logic [6:0] ridx;
    logic [255:0] rl;
    for (int i = 0; i < 128; i++) begin
      rl = rand_line();
      mem[i] = rl;
      ref_mem[i] = rl;
    end
    mem[5] = {32{8'hA5}}; ref_mem[5] = {32{8'hA5}};
    mem[3] = '0;          ref_mem[3] = '0;

    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("rst");
    aresetn = 1'b1;
    step();

    do_cpu(1'b0, 7'd5, 3'd0, 32'h0, 4'h0);
    chk("lit_load5", last_rdata, {32{8'hA5}});
    do_cpu(1'b1, 7'd3, 3'd2, 32'hDEADBEEF, 4'b0101);
    chk("lit_store3", last_dina, 256'h00AD00EF_00000000_00000000);
    do_cpu(1'b0, 7'd3, 3'd0, 32'h0, 4'h0);
    chk("lit_load3", last_rdata, 256'h00AD00EF_00000000_00000000);
    do_cpu(1'b1, 7'd3, 3'd5, 32'h12345678, 4'b0000);
    chk("lit_strb0", last_dina, 256'h00AD00EF_00000000_00000000);

    do_miss(7'd9, 1'b0, 0, 1'b0, 7'd0,
            256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    chk("lit_refill9", last_dinb,
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    chk("lit_done9", last_done, 1);
    do_cpu(1'b0, 7'd9, 3'd0, 32'h0, 4'h0);
    chk("lit_load9", last_rdata[31:0], 32'h11111111);
    chk("lit_load9_hi", last_rdata[255:224], 32'h88888888);

    do_miss(7'd4, 1'b1, 5, 1'b0, 7'd0, rand_line());
    do_miss(7'd7, 1'b0, 0, 1'b1, 7'd7, rand_line());
    chk("miss_then_load", last_rdata, ref_mem[7]);

    // Refill aborted by reset after four beats
    miss_req = 1'b1; miss_index = 7'd12; miss_dirty = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      rf_valid = 1'b1; rf_data = $urandom;
      step();
    end
    #2;
    aresetn = 1'b0;
    miss_req = 1'b0; rf_valid = 1'b0; rf_data = '0;
    #1;
    check_reset_outputs("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("abort_web", bram_web, 0);
      chk("abort_done", miss_done, 0);
    end
    aresetn = 1'b1;
    step();
    do_cpu(1'b0, 7'd12, 3'd0, 32'h0, 4'h0);
    do_miss(7'd12, 1'b0, 0, 1'b0, 7'd0, rand_line());

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      ridx = 7'($urandom_range(0, 15));
      case (op)
        0, 1, 2, 3: do_cpu(1'b0, ridx, 3'd0, 32'h0, 4'h0);
        4, 5, 6:    do_cpu(1'b1, ridx, 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        7:          do_miss(ridx, 1'b0, 0, 1'b0, 7'd0, rand_line());
        8:          do_miss(ridx, 1'b1, $urandom_range(0, 3), 1'b0, 7'd0, rand_line());
        default:    do_miss(ridx, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1,
                            7'($urandom_range(0, 15)), rand_line());
      endcase
      repeat ($urandom_range(0, 1)) step();
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
